// File: rtl/pulse_pkg.sv
// rtl/pulse_pkg.sv - shared FSM state type and counter sizing for pulse_stretcher
package pulse_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW_GAP
    } state_t;

    // Counter must hold max(width, gap) - 1; never narrower than one bit.
    function automatic int cnt_width(input int width, input int gap);
        int m;
        m = (width > gap) ? width : gap;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/load_down_counter.sv
// rtl/load_down_counter.sv - loadable down-counter with zero flag
module load_down_counter #(
    parameter int W = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (dec && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// rtl/pulse_stretcher.sv - fixed-width pulse stretcher; PULSE_STRETCHER_QUEUE_EN queues triggers
module pulse_stretcher
    import pulse_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int GAP    = 1,
    parameter int QDEPTH = 3
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         trig,
    output logic                         pulse,
    output logic                         busy,
    output logic [$clog2(QDEPTH+1)-1:0]  pending,
    output logic                         overflow
);

    localparam int CW = cnt_width(WIDTH, GAP);
    localparam int PW = $clog2(QDEPTH + 1);
    localparam logic [CW-1:0] WIDTH_LOAD = CW'(WIDTH - 1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP - 1);

    state_t        state;
    logic          cnt_load;
    logic          cnt_dec;
    logic [CW-1:0] cnt_value;
    logic          cnt_zero;
    logic          gap_done;
    logic          has_pending;
    logic          direct_start;
    logic          drop;

    assign gap_done     = (state == LOW_GAP) && cnt_zero;
    assign has_pending  = (pending != '0);
    // A trigger starts a pulse itself only from IDLE or at the gap exit with nothing queued.
    assign direct_start = trig && ((state == IDLE) || (gap_done && !has_pending));

    always_comb begin
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        cnt_value = WIDTH_LOAD;
        case (state)
            IDLE:    cnt_load = trig;
            HIGH: begin
                if (cnt_zero) begin
                    cnt_load  = 1'b1;
                    cnt_value = GAP_LOAD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            LOW_GAP: begin
                if (cnt_zero) cnt_load = has_pending || trig;
                else          cnt_dec  = 1'b1;
            end
            default: ;
        endcase
    end

    load_down_counter #(.W(CW)) u_cnt (
        .clock (clock),
        .reset (reset),
        .load  (cnt_load),
        .value (cnt_value),
        .dec   (cnt_dec),
        .zero  (cnt_zero)
    );

`ifdef PULSE_STRETCHER_QUEUE_EN
    localparam logic [PW-1:0] QMAX = PW'(QDEPTH);
    logic enqueue;
    logic consume;

    assign enqueue = trig && !direct_start;
    assign consume = gap_done && has_pending;
    assign drop    = enqueue && !consume && (pending == QMAX);

    always_ff @(posedge clock) begin
        if (!reset) begin
            pending <= '0;
        end else if (enqueue && !consume && pending != QMAX) begin
            pending <= pending + PW'(1);
        end else if (consume && !enqueue) begin
            pending <= pending - PW'(1);
        end
    end
`else
    assign pending = '0;
    assign drop    = trig && !direct_start;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            pulse    <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            overflow <= drop;
            case (state)
                IDLE: begin
                    if (trig) begin
                        state <= HIGH;
                        pulse <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                HIGH: begin
                    if (cnt_zero) begin
                        state <= LOW_GAP;
                        pulse <= 1'b0;
                    end
                end
                LOW_GAP: begin
                    if (cnt_zero) begin
                        if (has_pending || trig) begin
                            state <= HIGH;
                            pulse <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    pulse <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb/tb_pulse_stretcher.sv - self-checking bench for pulse_stretcher
module tb_pulse_stretcher;

`ifdef PULSE_STRETCHER_QUEUE_EN
    localparam bit QEN = 1'b1;
`else
    localparam bit QEN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       trig  = 1'b0;
    logic       pulse0, busy0, ovf0;
    logic [1:0] pend0;
    logic       pulse1, busy1, ovf1;
    logic [1:0] pend1;

    always #5 clock = ~clock;

    pulse_stretcher #(.WIDTH(4), .GAP(1), .QDEPTH(3)) dut (
        .clock    (clock),
        .reset    (reset),
        .trig     (trig),
        .pulse    (pulse0),
        .busy     (busy0),
        .pending  (pend0),
        .overflow (ovf0)
    );

    pulse_stretcher #(.WIDTH(2), .GAP(3), .QDEPTH(2)) dut_b (
        .clock    (clock),
        .reset    (reset),
        .trig     (trig),
        .pulse    (pulse1),
        .busy     (busy1),
        .pending  (pend1),
        .overflow (ovf1)
    );

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit rstn;
        bit trg;
        bit pulse;
        bit busy;
        int pend;
        bit ovf;
    } vec_t;

    vec_t tbl[8];

    task automatic run_table();
        for (int i = 0; i < 8; i++) begin
            reset = tbl[i].rstn;
            trig  = tbl[i].trg;
            @(posedge clock); #1;
            chk($sformatf("tbl%0d.pulse", i), int'(pulse0), int'(tbl[i].pulse));
            chk($sformatf("tbl%0d.busy", i),  int'(busy0),  int'(tbl[i].busy));
            chk($sformatf("tbl%0d.pending", i), int'(pend0), tbl[i].pend);
            chk($sformatf("tbl%0d.overflow", i), int'(ovf0), int'(tbl[i].ovf));
        end
        trig = 1'b0;
    endtask

    // Hand sequences: index = cycle; trig driven in cycle c, outputs checked in cycle c+1.
    int s_trig[24], s_pulse[24], s_ovf[24], s_pend[24];

    task automatic run_seq(input string name);
        for (int c = 0; c < 23; c++) begin
            trig = s_trig[c][0];
            @(posedge clock); #1;
            chk($sformatf("%s.pulse@%0d", name, c + 1), int'(pulse0), s_pulse[c+1]);
            chk($sformatf("%s.overflow@%0d", name, c + 1), int'(ovf0), s_ovf[c+1]);
            if (s_pend[c+1] >= 0)
                chk($sformatf("%s.pending@%0d", name, c + 1), int'(pend0), s_pend[c+1]);
        end
        trig = 1'b0;
        repeat (12) @(posedge clock);
        #1;
        chk($sformatf("%s.drain_busy", name), int'(busy0), 0);
    endtask

    // Reference model: a pulse is a start cycle s; high for s..s+W-1, low gap up to s+W+G-1.
    int mw[2] = '{4, 2};
    int mg[2] = '{1, 3};
    int mq[2] = '{3, 2};
    int m_start[2] = '{-100, -100};
    int m_pend[2]  = '{0, 0};
    int m_ovf[2]   = '{0, 0};
    int t = 0;

    task automatic model_step(input int i);
        int last;
        last = m_start[i] + mw[i] + mg[i] - 1;
        m_ovf[i] = 0;
        if (!reset) begin
            m_start[i] = -100;
            m_pend[i]  = 0;
        end else if (m_start[i] < 0 || t > last) begin
            if (trig) m_start[i] = t + 1;
        end else if (t == last) begin
            if (m_pend[i] > 0) begin
                m_start[i] = t + 1;
                if (!trig) m_pend[i]--;
            end else if (trig) begin
                m_start[i] = t + 1;
            end
        end else if (trig) begin
            if (QEN && m_pend[i] < mq[i]) m_pend[i]++;
            else m_ovf[i] = 1;
        end
    endtask

    task automatic model_cycle();
        int s, ep, eb;
        int ap, ab, an, ao;
        model_step(0);
        model_step(1);
        @(posedge clock); #1;
        t++;
        for (int i = 0; i < 2; i++) begin
            s  = m_start[i];
            ep = (s >= 0 && t >= s && t < s + mw[i]) ? 1 : 0;
            eb = (s >= 0 && t >= s && t < s + mw[i] + mg[i]) ? 1 : 0;
            ap = (i == 0) ? int'(pulse0) : int'(pulse1);
            ab = (i == 0) ? int'(busy0)  : int'(busy1);
            an = (i == 0) ? int'(pend0)  : int'(pend1);
            ao = (i == 0) ? int'(ovf0)   : int'(ovf1);
            chk($sformatf("rnd%0d.pulse@%0d", i, t), ap, ep);
            chk($sformatf("rnd%0d.busy@%0d", i, t), ab, eb);
            chk($sformatf("rnd%0d.pending@%0d", i, t), an, m_pend[i]);
            chk($sformatf("rnd%0d.overflow@%0d", i, t), ao, m_ovf[i]);
        end
    endtask

    initial begin
        tbl[0] = '{rstn: 1'b0, trg: 1'b1, pulse: 1'b0, busy: 1'b0, pend: 0, ovf: 1'b0};
        tbl[1] = '{rstn: 1'b1, trg: 1'b1, pulse: 1'b1, busy: 1'b1, pend: 0, ovf: 1'b0};
        tbl[2] = '{rstn: 1'b1, trg: 1'b0, pulse: 1'b1, busy: 1'b1, pend: 0, ovf: 1'b0};
        tbl[3] = '{rstn: 1'b1, trg: 1'b0, pulse: 1'b1, busy: 1'b1, pend: 0, ovf: 1'b0};
        tbl[4] = '{rstn: 1'b1, trg: 1'b0, pulse: 1'b1, busy: 1'b1, pend: 0, ovf: 1'b0};
        tbl[5] = '{rstn: 1'b1, trg: 1'b0, pulse: 1'b0, busy: 1'b1, pend: 0, ovf: 1'b0};
        tbl[6] = '{rstn: 1'b1, trg: 1'b0, pulse: 1'b0, busy: 1'b0, pend: 0, ovf: 1'b0};
        tbl[7] = '{rstn: 1'b1, trg: 1'b0, pulse: 1'b0, busy: 1'b0, pend: 0, ovf: 1'b0};

        run_table();

`ifdef PULSE_STRETCHER_QUEUE_EN
        s_trig  = '{1,1,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
        s_pulse = '{0,1,1,1,1,0,1,1,1,1,0,1,1,1,1,0,0,0,0,0,0,0,0,0};
        s_ovf   = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
        s_pend  = '{0,0,1,2,2,2,1,1,1,1,1,0,0,0,0,0,0,0,0,0,0,0,0,0};
        run_seq("burst");

        s_trig  = '{1,1,1,1,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
        s_pulse = '{0,1,1,1,1,0,1,1,1,1,0,1,1,1,1,0,1,1,1,1,0,0,0,0};
        s_ovf   = '{0,0,0,0,0,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
        s_pend  = '{0,0,1,2,3,3,2,2,2,2,2,1,1,1,1,1,0,0,0,0,0,0,0,0};
        run_seq("overflow");

        s_trig  = '{1,1,1,1,0,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
        s_pulse = '{0,1,1,1,1,0,1,1,1,1,0,1,1,1,1,0,1,1,1,1,0,1,1,1};
        s_ovf   = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
        s_pend  = '{0,0,1,2,3,3,3,3,3,3,3,2,2,2,2,2,1,1,1,1,1,0,0,0};
        run_seq("simul_consume");
`else
        s_trig  = '{1,0,1,0,0,1,0,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
        s_pulse = '{0,1,1,1,1,0,1,1,1,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
        s_ovf   = '{0,0,0,1,0,0,0,0,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
        s_pend  = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
        run_seq("drop");
`endif

        // Reset in the middle of a pulse with triggers queued (when queueing exists).
        for (int c = 0; c < 3; c++) begin
            trig = 1'b1;
            @(posedge clock); #1;
        end
        trig = 1'b0;
        chk("midreset.pre_pending", int'(pend0), QEN ? 2 : 0);
        chk("midreset.pre_pulse", int'(pulse0), 1);
        reset = 1'b0;
        trig  = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clock); #1;
            chk($sformatf("midreset.pulse%0d", c), int'(pulse0), 0);
            chk($sformatf("midreset.busy%0d", c), int'(busy0), 0);
            chk($sformatf("midreset.pending%0d", c), int'(pend0), 0);
            chk($sformatf("midreset.overflow%0d", c), int'(ovf0), 0);
        end
        run_table();

        // Randomized run against the reference model, with occasional resets.
        reset = 1'b0;
        trig  = 1'b0;
        model_cycle();
        for (int blk = 0; blk < 8; blk++) begin
            int dens;
            dens = $urandom_range(5, 90);
            for (int c = 0; c < 500; c++) begin
                trig  = ($urandom_range(0, 99) < dens);
                reset = ($urandom_range(0, 299) != 0);
                model_cycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pulse_stretcher.md
# pulse_stretcher

Converts single-cycle event pulses, such as rising-edge detector outputs, back into clean fixed-width output pulses separated by a guaranteed low gap. It sits between edge/event detection logic and slow consumers such as LEDs, seven-segment blink logic, or handshake inputs that need a pulse longer than one cycle. Triggers that arrive while a pulse is in progress are either queued or dropped, depending on build configuration.

## Interface
- WIDTH, 4, output pulse length in cycles; legal range ≥1
- GAP, 1, minimum low cycles after every pulse; legal range ≥1
- QDEPTH, 3, maximum queued triggers; legal range ≥1
- clock  input  1  the single clock; all state changes on posedge
- reset  input  1  synchronous, active-low reset; sampled on posedge clock
- trig  input  1  event input; every clock edge with trig=1 counts as one event
- pulse  output  1  stretched pulse; registered
- busy  output  1  1 whenever the FSM is not in IDLE
- pending  output  $clog2(QDEPTH+1)  number of queued triggers
- overflow  output  1  one-cycle flag asserted on the cycle after a trigger is dropped

## Operation
- FSM states, held in a registered state variable:
  - IDLE: pulse=0.
  - HIGH: pulse=1. Down-counter cnt starts at WIDTH-1.
  - LOW_GAP: pulse=0. cnt starts at GAP-1.
- Transitions out of IDLE:
  - trig=1 → HIGH, load cnt=WIDTH-1.
- Transitions out of HIGH:
  - cnt==0 → LOW_GAP, load cnt=GAP-1.
  - otherwise decrement cnt.
- Transitions out of LOW_GAP when cnt==0:
  - pending>0 or trig=1 → HIGH, load cnt=WIDTH-1.
  - otherwise → IDLE.
- Transitions out of LOW_GAP when cnt≠0: decrement cnt.
- Trigger in HIGH or LOW_GAP: handled per Configuration.
- LOW_GAP exit consumes a trigger as follows:
  - If pending>0, one queued trigger is consumed (pending-1).
  - If pending==0, a simultaneous trig is consumed directly and pending stays 0.
- Simultaneous trig and consume with pending>0: net pending unchanged; no overflow, even when pending==QDEPTH.
- Width rule: cnt is $clog2(max(WIDTH,GAP)) bits, minimum 1 bit. No wrap-around is possible because cnt is always reloaded at 0.
- Reset, including mid-pulse or mid-queue:
  - state=IDLE, cnt=0, pending=0.
  - pulse=0, busy=0, overflow=0.
  - trig is ignored while reset=0.

## Timing
- Latency: trig=1 sampled at edge k → pulse=1 for cycles k+1 … k+WIDTH.
- After every pulse: pulse=0 for cycles k+WIDTH+1 … k+WIDTH+GAP.
- Back-to-back queued pulses therefore have a period of WIDTH+GAP.
- busy rises with pulse. It falls one cycle after the last LOW_GAP cycle, when the FSM returns to IDLE.
- overflow is high for exactly one cycle, the cycle after the dropped trig was sampled.
- pending updates on the same edge that samples trig.

## Configuration
- PULSE_STRETCHER_QUEUE_EN defined:
  - trig in HIGH or LOW_GAP increments pending.
  - pending saturates at QDEPTH.
  - trig while pending==QDEPTH with no simultaneous consume sets overflow.
- PULSE_STRETCHER_QUEUE_EN undefined:
  - Queue logic is removed and pending is tied to 0.
  - trig in HIGH or LOW_GAP is dropped and sets overflow.
  - The exception is the final LOW_GAP cycle: a trig there starts the next pulse directly and is not dropped.

## Structure
- Package pulse_pkg holds the FSM state typedef enum {IDLE, HIGH, LOW_GAP}.
- Sub-module load_down_counter provides the loadable down-counter with a zero flag, parameterised by width. It is instantiated once for cnt.
- The pending saturating up/down counter is inline and lives inside the macro guard.

## Test plan
- Single pulse, WIDTH=4, GAP=1: trig at cycle 0 → pulse=1 cycles 1–4, 0 at cycle 5; busy falls at cycle 6.
- Queued burst, macro defined, QDEPTH=3: trig at cycles 0,1,2 → pulses at cycles 1–4, 6–9, 11–14; pending 0→1→2→1→0; overflow never asserted.
- Overflow, macro defined, QDEPTH=3: trig on 5 consecutive cycles from 0 → 4 pulses total; overflow=1 at cycle 5 only; pending peaks at 3.
- Macro undefined: trig at cycles 0 and 2 → one pulse at cycles 1–4; overflow=1 at cycle 3; a trig at cycle 5 gives a pulse at cycles 6–9 with no overflow.
- Simultaneous trig and consume, macro defined, pending=3 at the LOW_GAP exit with trig=1: pending stays 3, overflow=0.
- Reset mid-pulse: reset=0 at cycle 2 of a pulse with pending=2 → next cycle pulse=0, busy=0, pending=0; after release, trig behaves as from a fresh start.
